// File: rtl/touch_pad_pkg.sv
// Shared event encodings and sizing helpers
// for the touch pad reader.
package touch_pad_pkg;

  localparam int KIND_W = 2;

  typedef enum logic [KIND_W-1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } evt_kind_e;

  function automatic int pad_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/touch_pad_debounce.sv
// One pad: synchroniser, debounce counter,
// hold counter and single-cycle event pulses.
module touch_pad_debounce #(
  parameter int DEBOUNCE_CYCLES   = 48000,
  parameter int LONG_PRESS_CYCLES = 48000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_n,
  output logic pressed,
  output logic press_evt,
  output logic release_evt,
  output logic long_evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_LAST =
    LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_SAT =
    LW'(LONG_PRESS_CYCLES);

  logic [1:0]    sync_q;
  logic          sync;
  logic          flip;
  logic [DW-1:0] db_cnt;
  logic [LW-1:0] hold_cnt;

  assign sync = ~sync_q[1];
  assign flip = (sync != pressed) &&
                (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      pressed     <= 1'b0;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      long_evt    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], pad_n};
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      long_evt    <= 1'b0;
      if (sync == pressed) begin
        db_cnt <= '0;
      end else if (flip) begin
        db_cnt      <= '0;
        pressed     <= sync;
        press_evt   <= sync;
        release_evt <= ~sync;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
      // A release on the maturing cycle wins over LONG
      if (flip && sync) begin
        hold_cnt <= '0;
      end else if (pressed && !flip) begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt <= HOLD_SAT;
          long_evt <= 1'b1;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_cnt <= hold_cnt + LW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/touch_pad_decoder.sv
// Touch pad reader: per-pad debounce, pending
// slots, round-robin arbiter, event stream out.
module touch_pad_decoder
  import touch_pad_pkg::*;
#(
  parameter int NUM_PADS          = 2,
  parameter int DEBOUNCE_CYCLES   = 48000,
  parameter int LONG_PRESS_CYCLES = 48000000,
  localparam int PW = pad_w(NUM_PADS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PADS-1:0] pad_n,
  output logic [NUM_PADS-1:0] pressed,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [PW-1:0]       evt_pad,
  output logic [KIND_W-1:0]   evt_kind,
  output logic                evt_dropped
);

  logic [NUM_PADS-1:0] press_e;
  logic [NUM_PADS-1:0] rel_e;
  logic [NUM_PADS-1:0] long_e;
  logic [NUM_PADS-1:0] new_e;
  logic [NUM_PADS-1:0] slot_v;
  logic [NUM_PADS-1:0] drain;
  logic [NUM_PADS-1:0] lost;
  evt_kind_e           new_k  [NUM_PADS];
  evt_kind_e           slot_k [NUM_PADS];

  logic          load;
  logic          found;
  logic [PW-1:0] gnt;
  logic [PW-1:0] last;

  assign load = ~evt_valid | evt_ready;
  assign lost = new_e & slot_v & ~drain;

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    evt_kind_e kind_q;
    logic      v_q;

    touch_pad_debounce #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_db (
      .clk        (clk),
      .rst_n      (rst_n),
      .pad_n      (pad_n[gi]),
      .pressed    (pressed[gi]),
      .press_evt  (press_e[gi]),
      .release_evt(rel_e[gi]),
      .long_evt   (long_e[gi])
    );

    assign new_e[gi] = press_e[gi] | rel_e[gi] |
                       long_e[gi];
    assign new_k[gi] = press_e[gi] ? EVT_PRESS :
                       rel_e[gi]   ? EVT_RELEASE :
                                     EVT_LONG;
    assign drain[gi] = load & found &
                       (gnt == PW'(gi));
    assign slot_v[gi] = v_q;
    assign slot_k[gi] = kind_q;

    // A slot emptied this cycle may take a new event
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q    <= 1'b0;
        kind_q <= EVT_PRESS;
      end else if (new_e[gi] &&
                   (!v_q || drain[gi])) begin
        v_q    <= 1'b1;
        kind_q <= new_k[gi];
      end else if (drain[gi]) begin
        v_q <= 1'b0;
      end
    end
  end

  always_comb begin
    int s;
    logic [PW-1:0] idx;
    found = 1'b0;
    gnt   = '0;
    s     = 0;
    idx   = '0;
    for (int k = 1; k <= NUM_PADS; k++) begin
      s = int'(last) + k;
      if (s >= NUM_PADS) s = s - NUM_PADS;
      idx = PW'(s);
      if (!found && slot_v[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid   <= 1'b0;
      evt_pad     <= '0;
      evt_kind    <= '0;
      evt_dropped <= 1'b0;
      last        <= '0;
    end else begin
      evt_dropped <= |lost;
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_pad  <= gnt;
          evt_kind <= slot_k[gnt];
          last     <= gnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_touch_pad_decoder.sv
// Directed bench for touch_pad_decoder with
// small debounce and long-press constants.
module tb_touch_pad_decoder;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pad_n;
  logic [1:0] pressed;
  logic       evt_valid;
  logic       evt_ready;
  logic [0:0] evt_pad;
  logic [1:0] evt_kind;
  logic       evt_dropped;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int drop_cnt = 0;
  int q_pad[$];
  int q_kind[$];
  int q_stamp[$];

  touch_pad_decoder #(
    .NUM_PADS         (2),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_n      (pad_n),
    .pressed    (pressed),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_pad    (evt_pad),
    .evt_kind   (evt_kind),
    .evt_dropped(evt_dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready) begin
        q_pad.push_back(int'(evt_pad));
        q_kind.push_back(int'(evt_kind));
        q_stamp.push_back(cyc_cnt);
      end
      if (evt_dropped) drop_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks += 5;
    if (pressed !== 2'b00) begin
      errors++;
      $display("FAIL rst_pressed got %b want 00", pressed);
    end
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", evt_valid);
    end
    if (evt_pad !== 1'b0) begin
      errors++;
      $display("FAIL rst_pad got %b want 0", evt_pad);
    end
    if (evt_kind !== 2'd0) begin
      errors++;
      $display("FAIL rst_kind got %0d want 0", evt_kind);
    end
    if (evt_dropped !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop got %b want 0", evt_dropped);
    end
  endtask

  task automatic test_clean_press();
    int base;
    int c0;
    evt_ready = 1'b1;
    base = q_pad.size();
    c0 = cyc_cnt;
    pad_n[0] = 1'b0;
    cyc(5);
    checks++;
    if (pressed !== 2'b00) begin
      errors++;
      $display("FAIL press_early got %b want 00", pressed);
    end
    cyc(1);
    checks++;
    if (pressed !== 2'b01) begin
      errors++;
      $display("FAIL press_level got %b want 01", pressed);
    end
    cyc(4);
    pad_n[0] = 1'b1;
    cyc(14);
    checks++;
    if (q_pad.size() - base !== 2) begin
      errors++;
      $display("FAIL press_count got %0d want 2",
               q_pad.size() - base);
    end else begin
      checks += 4;
      if (q_pad[base] !== 0 ||
          q_kind[base] !== K_PRESS) begin
        errors++;
        $display("FAIL press_evt got pad%0d k%0d want pad0 k0",
                 q_pad[base], q_kind[base]);
      end
      if (q_stamp[base] !== c0 + 8) begin
        errors++;
        $display("FAIL press_lat got %0d want %0d",
                 q_stamp[base], c0 + 8);
      end
      if (q_kind[base+1] !== K_RELEASE) begin
        errors++;
        $display("FAIL rel_kind got %0d want 1",
                 q_kind[base+1]);
      end
      if (q_stamp[base+1] !== c0 + 18) begin
        errors++;
        $display("FAIL rel_lat got %0d want %0d",
                 q_stamp[base+1], c0 + 18);
      end
    end
  endtask

  task automatic test_glitch();
    int base;
    base = q_pad.size();
    pad_n[0] = 1'b0;
    cyc(3);
    pad_n[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(2);
      checks++;
      if (pressed !== 2'b00) begin
        errors++;
        $display("FAIL glitch_level got %b want 00", pressed);
      end
    end
    cyc(4);
    checks++;
    if (q_pad.size() !== base) begin
      errors++;
      $display("FAIL glitch_evt got %0d want 0",
               q_pad.size() - base);
    end
  endtask

  task automatic test_long_hold();
    int base;
    int c0;
    evt_ready = 1'b1;
    base = q_pad.size();
    c0 = cyc_cnt;
    pad_n[1] = 1'b0;
    cyc(40);
    checks++;
    if (pressed !== 2'b10) begin
      errors++;
      $display("FAIL long_level got %b want 10", pressed);
    end
    pad_n[1] = 1'b1;
    cyc(14);
    checks++;
    if (q_pad.size() - base !== 3) begin
      errors++;
      $display("FAIL long_count got %0d want 3",
               q_pad.size() - base);
    end else begin
      checks += 3;
      if (q_pad[base] !== 1 || q_kind[base] !== K_PRESS ||
          q_stamp[base] !== c0 + 8) begin
        errors++;
        $display("FAIL long_press got p%0d k%0d t%0d want p1 k0 t%0d",
                 q_pad[base], q_kind[base],
                 q_stamp[base], c0 + 8);
      end
      if (q_pad[base+1] !== 1 ||
          q_kind[base+1] !== K_LONG ||
          q_stamp[base+1] !== c0 + 28) begin
        errors++;
        $display("FAIL long_evt got p%0d k%0d t%0d want p1 k2 t%0d",
                 q_pad[base+1], q_kind[base+1],
                 q_stamp[base+1], c0 + 28);
      end
      if (q_pad[base+2] !== 1 ||
          q_kind[base+2] !== K_RELEASE ||
          q_stamp[base+2] !== c0 + 48) begin
        errors++;
        $display("FAIL long_rel got p%0d k%0d t%0d want p1 k1 t%0d",
                 q_pad[base+2], q_kind[base+2],
                 q_stamp[base+2], c0 + 48);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int c0;
    int d0;
    evt_ready = 1'b0;
    d0 = drop_cnt;
    c0 = cyc_cnt;
    pad_n = 2'b00;
    cyc(6);
    checks++;
    if (pressed !== 2'b11) begin
      errors++;
      $display("FAIL bp_level got %b want 11", pressed);
    end
    pad_n[0] = 1'b1;
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_pad !== 1'b0 ||
          evt_kind !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold got v%b p%0d k%0d want v1 p0 k0",
                 evt_valid, evt_pad, evt_kind);
      end
      if (i < 4) cyc(1);
    end
    checks++;
    if (pressed !== 2'b10) begin
      errors++;
      $display("FAIL bp_rel_level got %b want 10", pressed);
    end
    pad_n[0] = 1'b0;
    cyc(8);
    checks += 2;
    if (drop_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL bp_drop got %0d want 1", drop_cnt - d0);
    end
    if (evt_valid !== 1'b1 || evt_pad !== 1'b0 ||
        evt_kind !== 2'd0) begin
      errors++;
      $display("FAIL bp_hold2 got v%b p%0d k%0d want v1 p0 k0",
               evt_valid, evt_pad, evt_kind);
    end
    base = q_pad.size();
    evt_ready = 1'b1;
    cyc(3);
    checks++;
    if (q_pad.size() - base !== 3) begin
      errors++;
      $display("FAIL bp_count got %0d want 3",
               q_pad.size() - base);
    end else begin
      checks += 3;
      if (q_pad[base] !== 0 || q_kind[base] !== K_PRESS ||
          q_stamp[base] !== c0 + 20) begin
        errors++;
        $display("FAIL bp_first got p%0d k%0d t%0d want p0 k0 t%0d",
                 q_pad[base], q_kind[base],
                 q_stamp[base], c0 + 20);
      end
      if (q_pad[base+1] !== 1 ||
          q_kind[base+1] !== K_PRESS ||
          q_stamp[base+1] !== c0 + 21) begin
        errors++;
        $display("FAIL bp_second got p%0d k%0d t%0d want p1 k0 t%0d",
                 q_pad[base+1], q_kind[base+1],
                 q_stamp[base+1], c0 + 21);
      end
      if (q_pad[base+2] !== 0 ||
          q_kind[base+2] !== K_RELEASE ||
          q_stamp[base+2] !== c0 + 22) begin
        errors++;
        $display("FAIL bp_third got p%0d k%0d t%0d want p0 k1 t%0d",
                 q_pad[base+2], q_kind[base+2],
                 q_stamp[base+2], c0 + 22);
      end
    end
    pad_n = 2'b11;
    cyc(20);
    checks++;
    if (drop_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL bp_drop_total got %0d want 1",
               drop_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int c0;
    evt_ready = 1'b0;
    pad_n[0] = 1'b0;
    cyc(8);
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre got %b want 1", evt_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_pad !== 1'b0 ||
        evt_kind !== 2'd0 || pressed !== 2'b00) begin
      errors++;
      $display("FAIL rm_clear got v%b p%0d k%0d l%b want 0 0 0 00",
               evt_valid, evt_pad, evt_kind, pressed);
    end
    cyc(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    base = q_pad.size();
    c0 = cyc_cnt;
    cyc(5);
    checks++;
    if (pressed !== 2'b00) begin
      errors++;
      $display("FAIL rm_early got %b want 00", pressed);
    end
    cyc(1);
    checks++;
    if (pressed !== 2'b01) begin
      errors++;
      $display("FAIL rm_level got %b want 01", pressed);
    end
    cyc(3);
    checks++;
    if (q_pad.size() - base !== 1) begin
      errors++;
      $display("FAIL rm_count got %0d want 1",
               q_pad.size() - base);
    end else begin
      checks++;
      if (q_pad[base] !== 0 || q_kind[base] !== K_PRESS ||
          q_stamp[base] !== c0 + 8) begin
        errors++;
        $display("FAIL rm_evt got p%0d k%0d t%0d want p0 k0 t%0d",
                 q_pad[base], q_kind[base],
                 q_stamp[base], c0 + 8);
      end
    end
    pad_n[0] = 1'b1;
    cyc(12);
  endtask

  task automatic test_long_coincident();
    int base;
    int c0;
    evt_ready = 1'b1;
    base = q_pad.size();
    c0 = cyc_cnt;
    pad_n[0] = 1'b0;
    cyc(20);
    pad_n[0] = 1'b1;
    cyc(14);
    checks++;
    if (q_pad.size() - base !== 2) begin
      errors++;
      $display("FAIL co_count got %0d want 2",
               q_pad.size() - base);
    end else begin
      checks += 2;
      if (q_kind[base] !== K_PRESS ||
          q_stamp[base] !== c0 + 8) begin
        errors++;
        $display("FAIL co_press got k%0d t%0d want k0 t%0d",
                 q_kind[base], q_stamp[base], c0 + 8);
      end
      if (q_pad[base+1] !== 0 ||
          q_kind[base+1] !== K_RELEASE ||
          q_stamp[base+1] !== c0 + 28) begin
        errors++;
        $display("FAIL co_rel got p%0d k%0d t%0d want p0 k1 t%0d",
                 q_pad[base+1], q_kind[base+1],
                 q_stamp[base+1], c0 + 28);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pad_n = 2'b11;
    evt_ready = 1'b1;
    cyc(2);
    test_reset();
    rst_n = 1'b1;
    cyc(2);
    test_clean_press();
    test_glitch();
    test_long_hold();
    test_backpressure();
    test_reset_mid();
    test_long_coincident();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
